// File: rtl/result_ascii_tx.sv
// Converts a binary result to ASCII decimal digits and streams them out one byte at a time.
// Latency: the first byte appears WIDTH+1 cycles after the request. The byte is held while send_ready is low.
module result_ascii_tx #(
    parameter int WIDTH     = 32,
    parameter int DIGITS    = 10,
    parameter int APPEND_NL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             busy,
    output logic [7:0]       send_val,
    output logic             send_val_valid,
    input  logic             send_ready,
    output logic             send_val_done
);

    localparam int BW = 4 * DIGITS;
    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, CONVERT, EMIT, NL, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [BW-1:0]    bcd;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    ptr;

    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_shifted;
    logic [PW-1:0]    top_ptr;

    function automatic logic [3:0] nibble(input logic [BW-1:0] b, input logic [PW-1:0] p);
        logic [3:0] n;
        n = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (PW'(i) == p) n = b[4*i +: 4];
        end
        return n;
    endfunction

    function automatic logic [7:0] ascii(input logic [3:0] n);
        return 8'h30 | {4'h0, n};
    endfunction

    // Per-nibble +3 correction (no inter-nibble carry), then one-bit left shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_shifted = (bcd_adj << 1) | BW'(shift_reg[WIDTH-1]);
    end

    // Most significant nonzero digit of the final value; defaults to digit 0.
    always_comb begin
        top_ptr = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_shifted[4*i +: 4] != 4'h0) top_ptr = PW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            shift_reg      <= '0;
            bcd            <= '0;
            cnt            <= '0;
            ptr            <= '0;
            busy           <= 1'b0;
            send_val       <= 8'h00;
            send_val_valid <= 1'b0;
            send_val_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        bcd       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd       <= bcd_shifted;
                    shift_reg <= shift_reg << 1;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        ptr            <= top_ptr;
                        send_val       <= ascii(nibble(bcd_shifted, top_ptr));
                        send_val_valid <= 1'b1;
                        state          <= EMIT;
                    end
                end
                EMIT: begin
                    if (send_ready) begin
                        if (ptr == '0) begin
                            if (APPEND_NL != 0) begin
                                send_val <= 8'h0A;
                                state    <= NL;
                            end else begin
                                send_val       <= 8'h00;
                                send_val_valid <= 1'b0;
                                send_val_done  <= 1'b1;
                                state          <= FIN;
                            end
                        end else begin
                            ptr      <= ptr - 1'b1;
                            send_val <= ascii(nibble(bcd, ptr - 1'b1));
                        end
                    end
                end
                NL: begin
                    if (send_ready) begin
                        send_val       <= 8'h00;
                        send_val_valid <= 1'b0;
                        send_val_done  <= 1'b1;
                        state          <= FIN;
                    end
                end
                FIN: begin
                    send_val_done <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_ascii_tx.sv
// Directed bench for result_ascii_tx: one instance with newline terminator, one without.
module tb_result_ascii_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid0, in_valid1;
    logic        send_ready;
    logic        busy0, vld0, done0, busy1, vld1, done1;
    logic [7:0]  val0, val1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    result_ascii_tx #(.WIDTH(32), .DIGITS(10), .APPEND_NL(1)) dut_nl (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid0),
        .busy(busy0), .send_val(val0), .send_val_valid(vld0),
        .send_ready(send_ready), .send_val_done(done0)
    );

    result_ascii_tx #(.WIDTH(32), .DIGITS(10), .APPEND_NL(0)) dut_raw (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid1),
        .busy(busy1), .send_val(val1), .send_val_valid(vld1),
        .send_ready(send_ready), .send_val_done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise the request for one edge and measure cycles until the first byte.
    task automatic start(input bit sel, input logic [31:0] d, input bit hold);
        int lat;
        in_data = d;
        if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        @(negedge clk);
        lat = 1;
        chk("busy_after_accept", sel ? busy1 : busy0, 1);
        if (hold) in_data = 32'd7;
        else begin
            in_valid0 = 1'b0;
            in_valid1 = 1'b0;
        end
        while (!(sel ? vld1 : vld0) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("first_byte_latency", lat, 33);
    endtask

    // Accept n bytes of s; every cycle the byte on offer must be valid and be s[idx].
    task automatic emit(input bit sel, input string s, input int n, input bit toggle);
        int idx;
        int cyc;
        bit r;
        bit pat[6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            r = toggle ? pat[cyc % 6] : 1'b1;
            send_ready = r;
            chk($sformatf("byte%0d_valid", idx), sel ? vld1 : vld0, 1);
            chk($sformatf("byte%0d_value", idx), sel ? val1 : val0, 32'(s[idx]));
            if (r) idx++;
            @(negedge clk);
            cyc++;
        end
        send_ready = 1'b0;
        chk("all_bytes_accepted", idx, n);
    endtask

    task automatic fin_chk(input bit sel);
        chk("done_strobe", sel ? done1 : done0, 1);
        chk("valid_low_in_fin", sel ? vld1 : vld0, 0);
        chk("busy_in_fin", sel ? busy1 : busy0, 1);
        @(negedge clk);
        chk("done_one_cycle", sel ? done1 : done0, 0);
        chk("idle_after_fin", sel ? busy1 : busy0, 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy0"}, busy0, 0);
        chk({tag, "_valid0"}, vld0, 0);
        chk({tag, "_val0"}, val0, 0);
        chk({tag, "_done0"}, done0, 0);
        chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_valid1"}, vld1, 0);
        chk({tag, "_done1"}, done1, 0);
    endtask

    initial begin
        rst        = 1'b1;
        in_data    = 32'd0;
        in_valid0  = 1'b0;
        in_valid1  = 1'b0;
        send_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_quiet("reset");

        // Zero gives a single "0" digit.
        start(0, 32'd0, 0);
        emit(0, "0\n", 2, 0);
        fin_chk(0);

        start(0, 32'd1234, 0);
        emit(0, "1234\n", 5, 0);
        fin_chk(0);

        start(0, 32'hFFFF_FFFF, 0);
        emit(0, "4294967295\n", 11, 0);
        fin_chk(0);

        // Stalling sink: byte must hold while ready is low.
        start(0, 32'd905, 0);
        emit(0, "905\n", 4, 1);
        fin_chk(0);

        // Request held high through the transfer is not queued.
        start(0, 32'd42, 1);
        emit(0, "42\n", 3, 0);
        fin_chk(0);
        in_valid0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_request_dropped_busy", busy0, 0);
        chk("held_request_dropped_valid", vld0, 0);

        // Reset in the middle of emitting abandons the transfer.
        start(0, 32'd123456, 0);
        emit(0, "123456\n", 2, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_quiet("mid_emit_reset");
        @(negedge clk);
        chk("no_done_after_reset", done0, 0);
        start(0, 32'd9, 0);
        emit(0, "9\n", 2, 0);
        fin_chk(0);

        // Same sequence without a terminator byte.
        start(1, 32'd123456, 0);
        emit(1, "123456", 2, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_quiet("mid_emit_reset_raw");
        @(negedge clk);
        chk("no_done_after_reset_raw", done1, 0);
        start(1, 32'd9, 0);
        emit(1, "9", 1, 0);
        fin_chk(1);

        start(1, 32'd0, 0);
        emit(1, "0", 1, 0);
        fin_chk(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
